irq_ctrl_multi: RTL and testbench

Parametrised successor to the single-timer/single-external interrupt controller for the HarvOS core. It adds:
- NUM_SRC external sources, each with its own synchroniser, edge/level gateway, enable and priority.
- A threshold-gated priority arbiter.
- A claim/complete handshake with the trap handler.

The machine timer remains a dedicated highest-priority source. The block sits between the SoC interrupt lines and the core's CSR/trap unit.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_gateway.sv | 89 ++++++++
 rtl/irq_ctrl_multi.sv | 98 +++++++++
 tb/tb_irq_ctrl_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the multi-source interrupt controller.
package irq_pkg;

  localparam logic [31:0] CAUSE_TIMER_DEFAULT    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXTERNAL_DEFAULT = 32'h8000_000B;
  localparam int unsigned ID_NONE                = 0;

  // Width of an id field covering 0 (none) plus ids 1..n.
  function automatic int unsigned id_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: synchroniser, edge detect and the pend/in_service/deferred
// state that enforces one outstanding claim per source.
module irq_gateway
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic en,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   sync_d;
  logic                   rise;
  logic                   pend;
  logic                   in_service;
  logic                   deferred;
  logic                   pend_n;
  logic                   in_service_n;
  logic                   deferred_n;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign rise   = sync & ~sync_d;
  assign pend_o = pend;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q[0] <= src;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_d <= sync;
    end
  end

  // An edge landing while claimed (or on the claim edge) is parked in deferred.
  always_comb begin
    pend_n       = pend;
    in_service_n = in_service;
    deferred_n   = deferred;
    if (claim) begin
      in_service_n = 1'b1;
      pend_n       = 1'b0;
      if (edge_mode && rise) begin
        deferred_n = 1'b1;
      end
    end else if (in_service) begin
      pend_n = 1'b0;
      if (edge_mode && rise) begin
        deferred_n = 1'b1;
      end
      if (complete) begin
        in_service_n = 1'b0;
        if (deferred || (edge_mode && rise)) begin
          pend_n     = 1'b1;
          deferred_n = 1'b0;
        end
      end
    end else if (edge_mode) begin
      pend_n = pend | rise;
    end else begin
      pend_n = sync & en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      in_service <= 1'b0;
      deferred   <= 1'b0;
    end else begin
      pend       <= pend_n;
      in_service <= in_service_n;
      deferred   <= deferred_n;
    end
  end

endmodule

// File: rtl/irq_ctrl_multi.sv
// Multi-source interrupt controller: per-source gateways, threshold-gated
// priority arbiter, dedicated timer path and claim/complete handshake.
module irq_ctrl_multi
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 8,
  parameter int unsigned PRIO_W         = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [31:0] CAUSE_TIMER    = CAUSE_TIMER_DEFAULT,
  parameter logic [31:0] CAUSE_EXTERNAL = CAUSE_EXTERNAL_DEFAULT,
  localparam int unsigned ID_W          = id_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_i,
  input  logic [NUM_SRC-1:0]        en_i,
  input  logic [NUM_SRC-1:0]        edge_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      global_ie_i,
  input  logic                      timer_irq_i,
  input  logic                      en_timer_i,
  input  logic                      claim_i,
  input  logic                      complete_i,
  input  logic [ID_W-1:0]           complete_id_i,
  output logic                      take_irq_o,
  output logic [31:0]               cause_o,
  output logic [ID_W-1:0]           claim_id_o,
  output logic [NUM_SRC-1:0]        pend_o,
  output logic                      set_mtip_o,
  output logic                      set_meip_o
);

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;
  logic               tmr;
  logic               ext_valid;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic               claim_ext;

  assign tmr        = timer_irq_i & en_timer_i;
  assign claim_ext  = claim_i & ~tmr & ext_valid;
  assign set_mtip_o = timer_irq_i;
  assign pend_o     = pend;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // Out-of-range ids decode to no source, so bad completes fall through.
    assign claim_vec[g]    = claim_ext && (best_id == ID_W'(g + 1));
    assign complete_vec[g] = complete_i && (complete_id_i == ID_W'(g + 1));

    irq_gateway #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_gw (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (src_i[g]),
      .en        (en_i[g]),
      .edge_mode (edge_i[g]),
      .claim     (claim_vec[g]),
      .complete  (complete_vec[g]),
      .pend_o    (pend[g])
    );
  end

  // Highest priority wins; strict compare keeps ties on the lowest index.
  always_comb begin
    ext_valid = 1'b0;
    best_id   = ID_W'(ID_NONE);
    best_prio = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pend[i] && en_i[i] && (prio_i[i*PRIO_W +: PRIO_W] > threshold_i) &&
          (!ext_valid || (prio_i[i*PRIO_W +: PRIO_W] > best_prio))) begin
        ext_valid = 1'b1;
        best_prio = prio_i[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_irq_o <= 1'b0;
      cause_o    <= 32'h0;
      set_meip_o <= 1'b0;
      claim_id_o <= '0;
    end else begin
      take_irq_o <= global_ie_i & (tmr | ext_valid);
      cause_o    <= tmr ? CAUSE_TIMER : (ext_valid ? CAUSE_EXTERNAL : 32'h0);
      set_meip_o <= ext_valid;
      if (claim_i) begin
        claim_id_o <= claim_ext ? best_id : ID_W'(ID_NONE);
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Directed self-checking bench for irq_ctrl_multi (NUM_SRC=8, PRIO_W=3, SYNC_STAGES=2).
module tb_irq_ctrl_multi;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned PRIO_W  = 3;
  localparam int unsigned ID_W    = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_i;
  logic [NUM_SRC-1:0]        en_i;
  logic [NUM_SRC-1:0]        edge_i;
  logic [NUM_SRC*PRIO_W-1:0] prio_i;
  logic [PRIO_W-1:0]         threshold_i;
  logic                      global_ie_i;
  logic                      timer_irq_i;
  logic                      en_timer_i;
  logic                      claim_i;
  logic                      complete_i;
  logic [ID_W-1:0]           complete_id_i;
  logic                      take_irq_o;
  logic [31:0]               cause_o;
  logic [ID_W-1:0]           claim_id_o;
  logic [NUM_SRC-1:0]        pend_o;
  logic                      set_mtip_o;
  logic                      set_meip_o;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  irq_ctrl_multi dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_i         (src_i),
    .en_i          (en_i),
    .edge_i        (edge_i),
    .prio_i        (prio_i),
    .threshold_i   (threshold_i),
    .global_ie_i   (global_ie_i),
    .timer_irq_i   (timer_irq_i),
    .en_timer_i    (en_timer_i),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .take_irq_o    (take_irq_o),
    .cause_o       (cause_o),
    .claim_id_o    (claim_id_o),
    .pend_o        (pend_o),
    .set_mtip_o    (set_mtip_o),
    .set_meip_o    (set_meip_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_claim();
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
  endtask

  task automatic do_complete(input logic [ID_W-1:0] id);
    complete_i    = 1'b1;
    complete_id_i = id;
    tick(1);
    complete_i    = 1'b0;
    complete_id_i = '0;
  endtask

  initial begin
    rst_n = 1'b0; src_i = '0; en_i = '0; edge_i = '0; prio_i = '0;
    threshold_i = '0; global_ie_i = 1'b0; timer_irq_i = 1'b0; en_timer_i = 1'b0;
    claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
    tick(2);
    chk("rst_take", 32'(take_irq_o), 32'h0);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_pend", 32'(pend_o), 32'h0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_take", 32'(take_irq_o), 32'h0);

    // Latency: src 3 edge, prio 5
    en_i = 8'hFF; edge_i = 8'hFF; global_ie_i = 1'b1;
    prio_i[3*PRIO_W +: PRIO_W] = 3'd5;
    tick(1);
    src_i[3] = 1'b1;
    tick(2);
    chk("lat_pend_k2", 32'(pend_o), 32'h00);
    tick(1);
    chk("lat_pend_k3", 32'(pend_o), 32'h08);
    chk("lat_take_k3", 32'(take_irq_o), 32'h0);
    tick(1);
    chk("lat_take_k4", 32'(take_irq_o), 32'h1);
    chk("lat_cause", cause_o, 32'h8000_000B);
    chk("lat_meip", 32'(set_meip_o), 32'h1);
    do_claim();
    chk("lat_claim_id", 32'(claim_id_o), 32'd4);
    chk("lat_claim_pend", 32'(pend_o), 32'h00);
    tick(1);
    chk("lat_take_after", 32'(take_irq_o), 32'h0);
    do_complete(4'd4);
    src_i[3] = 1'b0;

    // Priority and tie-break
    prio_i[1*PRIO_W +: PRIO_W] = 3'd4;
    prio_i[2*PRIO_W +: PRIO_W] = 3'd6;
    prio_i[5*PRIO_W +: PRIO_W] = 3'd6;
    src_i[1] = 1'b1; src_i[2] = 1'b1; src_i[5] = 1'b1;
    tick(3);
    chk("tie_pend", 32'(pend_o), 32'h26);
    do_claim();
    chk("tie_claim1", 32'(claim_id_o), 32'd3);
    do_complete(4'd3);
    do_claim();
    chk("tie_claim2", 32'(claim_id_o), 32'd6);
    do_complete(4'd6);
    do_claim();
    chk("tie_claim3", 32'(claim_id_o), 32'd2);
    chk("tie_pend_empty", 32'(pend_o), 32'h00);
    src_i[1] = 1'b0; src_i[2] = 1'b0; src_i[5] = 1'b0;
    tick(3);

    // Bad completes must leave source 1 (id 2) in service
    do_complete(4'd0);
    do_complete(4'd9);
    src_i[1] = 1'b1;
    tick(4);
    chk("defer_pend", 32'(pend_o), 32'h00);
    chk("defer_take", 32'(take_irq_o), 32'h0);
    do_complete(4'd2);
    chk("defer_release", 32'(pend_o), 32'h02);
    do_claim();
    chk("defer_claim", 32'(claim_id_o), 32'd2);
    do_complete(4'd2);
    src_i[1] = 1'b0;
    tick(3);

    // Level source 6 (id 7)
    edge_i[6] = 1'b0;
    prio_i[6*PRIO_W +: PRIO_W] = 3'd3;
    src_i[6] = 1'b1;
    tick(3);
    chk("lvl_pend", 32'(pend_o), 32'h40);
    do_claim();
    chk("lvl_claim", 32'(claim_id_o), 32'd7);
    tick(2);
    chk("lvl_held", 32'(pend_o), 32'h00);
    do_complete(4'd7);
    tick(1);
    chk("lvl_repend", 32'(pend_o), 32'h40);
    src_i[6] = 1'b0;
    tick(3);
    chk("lvl_drop", 32'(pend_o), 32'h00);

    // Threshold gating, then timer
    threshold_i = 3'd6;
    src_i[1] = 1'b1; src_i[2] = 1'b1;
    tick(5);
    chk("thr_pend", 32'(pend_o), 32'h06);
    chk("thr_take", 32'(take_irq_o), 32'h0);
    chk("thr_meip", 32'(set_meip_o), 32'h0);
    timer_irq_i = 1'b1; en_timer_i = 1'b1;
    tick(1);
    chk("tmr_mtip", 32'(set_mtip_o), 32'h1);
    chk("tmr_take", 32'(take_irq_o), 32'h1);
    chk("tmr_cause", cause_o, 32'h8000_0007);
    do_claim();
    chk("tmr_claim_id", 32'(claim_id_o), 32'd0);
    chk("tmr_claim_pend", 32'(pend_o), 32'h06);
    global_ie_i = 1'b0;
    tick(1);
    chk("mie_off_take", 32'(take_irq_o), 32'h0);
    global_ie_i = 1'b1; timer_irq_i = 1'b0; threshold_i = 3'd0;
    tick(1);
    chk("ext_take", 32'(take_irq_o), 32'h1);
    chk("ext_cause", cause_o, 32'h8000_000B);
    do_claim();
    chk("ext_claim", 32'(claim_id_o), 32'd3);
    chk("ext_pend", 32'(pend_o), 32'h02);

    // Asynchronous reset mid-claim
    #2;
    rst_n = 1'b0;
    src_i = '0; en_timer_i = 1'b0;
    #1;
    chk("arst_take", 32'(take_irq_o), 32'h0);
    chk("arst_cause", cause_o, 32'h0);
    chk("arst_claim", 32'(claim_id_o), 32'h0);
    chk("arst_pend", 32'(pend_o), 32'h0);
    chk("arst_meip", 32'(set_meip_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_take", 32'(take_irq_o), 32'h0);
    chk("post_rst_pend", 32'(pend_o), 32'h0);
    src_i[2] = 1'b1;
    tick(4);
    chk("post_rst_repend", 32'(pend_o), 32'h04);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
